gpp_comm_buffer: RTL and testbench

GPP_COMM_BUFFER -- requirements
Module: gpp_comm_buffer

---
 rtl/gpp_comm_buffer_pkg.sv | 13 +
 rtl/gpp_comm_buffer_fifo.sv | 65 ++++++
 rtl/gpp_comm_buffer.sv | 75 +++++++
 tb/tb_gpp_comm_buffer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/gpp_comm_buffer_pkg.sv
// Shared constants and helpers for the GPP <-> CP communication buffer.
//   DEFAULT_DEPTH / DEFAULT_WIDTH : default FIFO geometry
//   cnt_w(depth)                  : width of an occupancy counter holding 0..depth
package gpp_comm_buffer_pkg;

  localparam int unsigned DEFAULT_DEPTH = 8;
  localparam int unsigned DEFAULT_WIDTH = 16;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/gpp_comm_buffer_fifo.sv
// comm_fifo: circular-buffer FIFO with first-word fall-through head output.
//   clk, rst    : clock, synchronous active-low reset (clears storage too)
//   push, din   : write request/data; dropped while full
//   pop         : read request; ignored while empty
//   dout        : storage word at the read pointer
//   count       : registered occupancy 0..DEPTH
//   full, empty : decoded from the registered count only
module comm_fifo
  import gpp_comm_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  // Gating uses the pre-edge full/empty, so a push while full is dropped
  // even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/gpp_comm_buffer.sv
// gpp_comm_buffer: two independent FIFOs between the GPP datapath and the CP.
//   TX path: gpp_tx_data/gpp_tx_write -> cp_tx_data/cp_tx_valid/cp_tx_ready
//            gpp_trf_cp = TX not full, tx_count = TX occupancy
//   RX path: cp_rx_data/cp_rx_valid/cp_rx_ready -> RAM_rx_data_out/gpp_rx_read
//            data_rx_flag = RX not empty, rx_count = RX occupancy
//   tx_overflow / rx_underflow: sticky error flags, cleared only by reset
//   rst: synchronous, active-low
module gpp_comm_buffer
  import gpp_comm_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        gpp_tx_data,
  input  logic                    gpp_tx_write,
  output logic                    gpp_trf_cp,
  input  logic                    gpp_rx_read,
  output logic [WIDTH-1:0]        RAM_rx_data_out,
  output logic                    data_rx_flag,
  output logic [WIDTH-1:0]        cp_tx_data,
  output logic                    cp_tx_valid,
  input  logic                    cp_tx_ready,
  input  logic [WIDTH-1:0]        cp_rx_data,
  input  logic                    cp_rx_valid,
  output logic                    cp_rx_ready,
  output logic [cnt_w(DEPTH)-1:0] tx_count,
  output logic [cnt_w(DEPTH)-1:0] rx_count,
  output logic                    tx_overflow,
  output logic                    rx_underflow
);

  logic tx_full, tx_empty, rx_full, rx_empty;

  comm_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (gpp_tx_write),
    .pop   (cp_tx_ready),
    .din   (gpp_tx_data),
    .dout  (cp_tx_data),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  comm_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cp_rx_valid),
    .pop   (gpp_rx_read),
    .din   (cp_rx_data),
    .dout  (RAM_rx_data_out),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign gpp_trf_cp   = !tx_full;
  assign cp_tx_valid  = !tx_empty;
  assign cp_rx_ready  = !rx_full;
  assign data_rx_flag = !rx_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      if (gpp_tx_write && tx_full) tx_overflow  <= 1'b1;
      if (gpp_rx_read && rx_empty) rx_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gpp_comm_buffer.sv
// Self-checking bench for gpp_comm_buffer: directed scenarios followed by
// randomized traffic, compared every cycle against a queue-based model.
module tb_gpp_comm_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] gpp_tx_data;
  logic             gpp_tx_write;
  logic             gpp_trf_cp;
  logic             gpp_rx_read;
  logic [WIDTH-1:0] RAM_rx_data_out;
  logic             data_rx_flag;
  logic [WIDTH-1:0] cp_tx_data;
  logic             cp_tx_valid;
  logic             cp_tx_ready;
  logic [WIDTH-1:0] cp_rx_data;
  logic             cp_rx_valid;
  logic             cp_rx_ready;
  logic [3:0]       tx_count;
  logic [3:0]       rx_count;
  logic             tx_overflow;
  logic             rx_underflow;

  gpp_comm_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .gpp_tx_data     (gpp_tx_data),
    .gpp_tx_write    (gpp_tx_write),
    .gpp_trf_cp      (gpp_trf_cp),
    .gpp_rx_read     (gpp_rx_read),
    .RAM_rx_data_out (RAM_rx_data_out),
    .data_rx_flag    (data_rx_flag),
    .cp_tx_data      (cp_tx_data),
    .cp_tx_valid     (cp_tx_valid),
    .cp_tx_ready     (cp_tx_ready),
    .cp_rx_data      (cp_rx_data),
    .cp_rx_valid     (cp_rx_valid),
    .cp_rx_ready     (cp_rx_ready),
    .tx_count        (tx_count),
    .rx_count        (rx_count),
    .tx_overflow     (tx_overflow),
    .rx_underflow    (rx_underflow)
  );

  always #5 clk = ~clk;

  // Reference model: plain queues of buffered words plus sticky bits.
  logic [WIDTH-1:0] txq[$];
  logic [WIDTH-1:0] rxq[$];
  bit               m_ovf, m_unf, m_just_reset;
  int               checks = 0;
  int               errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("tx_count", 32'(tx_count), 32'(txq.size()));
    check("rx_count", 32'(rx_count), 32'(rxq.size()));
    check("gpp_trf_cp", 32'(gpp_trf_cp), 32'(txq.size() < DEPTH));
    check("cp_tx_valid", 32'(cp_tx_valid), 32'(txq.size() > 0));
    check("cp_rx_ready", 32'(cp_rx_ready), 32'(rxq.size() < DEPTH));
    check("data_rx_flag", 32'(data_rx_flag), 32'(rxq.size() > 0));
    check("tx_overflow", 32'(tx_overflow), 32'(m_ovf));
    check("rx_underflow", 32'(rx_underflow), 32'(m_unf));
    if (txq.size() > 0) check("cp_tx_data", 32'(cp_tx_data), 32'(txq[0]));
    else if (m_just_reset) check("cp_tx_data_rst", 32'(cp_tx_data), 32'h0);
    if (rxq.size() > 0) check("rx_data_out", 32'(RAM_rx_data_out), 32'(rxq[0]));
    else if (m_just_reset) check("rx_data_rst", 32'(RAM_rx_data_out), 32'h0);
  endtask

  // Advance one clock: apply the transfer rules to the model using the
  // inputs held across the edge, then compare after the edge.
  task automatic step();
    bit tx_push, tx_pop, rx_push, rx_pop;
    if (!rst) begin
      txq.delete();
      rxq.delete();
      m_ovf = 0;
      m_unf = 0;
      m_just_reset = 1;
    end else begin
      tx_push = gpp_tx_write && (txq.size() < DEPTH);
      tx_pop  = cp_tx_ready && (txq.size() > 0);
      rx_push = cp_rx_valid && (rxq.size() < DEPTH);
      rx_pop  = gpp_rx_read && (rxq.size() > 0);
      if (gpp_tx_write && txq.size() == DEPTH) m_ovf = 1;
      if (gpp_rx_read && rxq.size() == 0) m_unf = 1;
      if (tx_pop) void'(txq.pop_front());
      if (tx_push) txq.push_back(gpp_tx_data);
      if (rx_pop) void'(rxq.pop_front());
      if (rx_push) rxq.push_back(cp_rx_data);
      m_just_reset = 0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    gpp_tx_write = 0;
    gpp_tx_data  = '0;
    cp_tx_ready  = 0;
    gpp_rx_read  = 0;
    cp_rx_valid  = 0;
    cp_rx_data   = '0;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    // Reset, then idle.
    step();
    step();
    rst = 1;
    step();
    step();

    // TX: three words queued while CP not ready, then drained in order.
    for (int i = 1; i <= 3; i++) begin
      gpp_tx_write = 1;
      gpp_tx_data  = 16'(i * 16'h1111);
      step();
    end
    gpp_tx_write = 0;
    cp_tx_ready  = 1;
    for (int i = 0; i < 3; i++) step();
    cp_tx_ready = 0;
    step();

    // RX: fill, overrun by one, then read everything back.
    cp_rx_valid = 1;
    for (int i = 0; i < 9; i++) begin
      cp_rx_data = 16'(16'hA000 + i);
      step();
    end
    cp_rx_valid = 0;
    gpp_rx_read = 1;
    for (int i = 0; i < 8; i++) step();
    gpp_rx_read = 0;
    step();

    // RX at count 4 with simultaneous push/pop, long enough to wrap.
    cp_rx_valid = 1;
    for (int i = 0; i < 4; i++) begin
      cp_rx_data = 16'(16'hB000 + i);
      step();
    end
    gpp_rx_read = 1;
    for (int i = 4; i < 14; i++) begin
      cp_rx_data = 16'(16'hB000 + i);
      step();
    end
    cp_rx_valid = 0;
    for (int i = 0; i < 5; i++) step();
    gpp_rx_read = 0;

    // TX overflow and RX underflow stick until reset.
    gpp_tx_write = 1;
    for (int i = 0; i < 9; i++) begin
      gpp_tx_data = 16'(16'hC000 + i);
      step();
    end
    gpp_tx_write = 0;
    cp_tx_ready  = 1;
    for (int i = 0; i < 8; i++) step();
    cp_tx_ready = 0;
    step();

    // Reset while both FIFOs are half full and handshakes are active.
    gpp_tx_write = 1;
    cp_rx_valid  = 1;
    for (int i = 0; i < 4; i++) begin
      gpp_tx_data = 16'(16'hD000 + i);
      cp_rx_data  = 16'(16'hE000 + i);
      step();
    end
    cp_tx_ready = 1;
    gpp_rx_read = 1;
    rst = 0;
    step();
    rst = 1;
    idle_inputs();
    step();

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      gpp_tx_write = 1'($urandom_range(0, 1));
      gpp_tx_data  = 16'($urandom);
      cp_tx_ready  = ($urandom_range(0, 3) != 0);
      cp_rx_valid  = 1'($urandom_range(0, 1));
      cp_rx_data   = 16'($urandom);
      gpp_rx_read  = ($urandom_range(0, 2) == 0);
      rst          = ($urandom_range(0, 79) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
